// File: rtl/regfile_wr_sched.sv
// Write-port scheduler for the register file: zero-fills every register after reset
// or soft clear, then arbitrates two write-back requesters round-robin onto one port.
module regfile_wr_sched #(
   parameter int DW      = 32,
   parameter int AW      = 5,
   parameter int NREG    = 32,
   parameter int RA_ADDR = 31
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          req0_valid,
   output logic          req0_ready,
   input  logic [AW-1:0] req0_addr,
   input  logic [DW-1:0] req0_data,
   input  logic          req0_link,
   input  logic          req1_valid,
   output logic          req1_ready,
   input  logic [AW-1:0] req1_addr,
   input  logic [DW-1:0] req1_data,
   input  logic          req1_link,
   output logic          Reg_wr,
   output logic          ra_wr,
   output logic [AW-1:0] w_addr,
   output logic [DW-1:0] w_data,
   output logic          init_done,
   output logic          dbg_state,
   output logic          dbg_pri
);

   typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

   state_t        state;
   logic [AW-1:0] cnt;
   logic          pri;
   logic          gnt0;
   logic          gnt1;
   logic          xfer;
   logic [AW-1:0] sel_addr;
   logic [DW-1:0] sel_data;
   logic          sel_link;

   // Handshake: a transfer happens on a rising edge where reqN_valid & reqN_ready;
   // ready is a function of state, clr, pri and both valids only, so a requester
   // holds valid/addr/data/link stable until it sees ready.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (state == ST_RUN && !clr) begin
         if (req0_valid && req1_valid) begin
            gnt0 = !pri;
            gnt1 = pri;
         end else begin
            gnt0 = req0_valid;
            gnt1 = req1_valid;
         end
      end
   end

   assign req0_ready = gnt0;
   assign req1_ready = gnt1;
   assign xfer       = gnt0 | gnt1;
   assign sel_addr   = gnt1 ? req1_addr : req0_addr;
   assign sel_data   = gnt1 ? req1_data : req0_data;
   assign sel_link   = gnt1 ? req1_link : req0_link;
   assign dbg_state  = state;
   assign dbg_pri    = pri;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= ST_INIT;
         cnt       <= '0;
         pri       <= 1'b0;
         Reg_wr    <= 1'b0;
         ra_wr     <= 1'b0;
         w_addr    <= '0;
         w_data    <= '0;
         init_done <= 1'b0;
      end else if (clr) begin
         // Soft clear drops any write this cycle and restarts the fill from 0.
         state     <= ST_INIT;
         cnt       <= '0;
         pri       <= 1'b0;
         Reg_wr    <= 1'b0;
         ra_wr     <= 1'b0;
         init_done <= 1'b0;
      end else begin
         case (state)
            ST_INIT: begin
               Reg_wr <= 1'b1;
               ra_wr  <= 1'b0;
               w_addr <= cnt;
               w_data <= '0;
               if (cnt == AW'(NREG - 1)) begin
                  state     <= ST_RUN;
                  init_done <= 1'b1;
                  cnt       <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            ST_RUN: begin
               if (xfer) begin
                  w_data <= sel_data;
                  pri    <= gnt0;
                  if (sel_link) begin
                     Reg_wr <= 1'b0;
                     ra_wr  <= 1'b1;
                     w_addr <= AW'(RA_ADDR);
                  end else begin
                     // Register 0 is hardwired: accept the write but never enable it.
                     Reg_wr <= (sel_addr != '0);
                     ra_wr  <= 1'b0;
                     w_addr <= sel_addr;
                  end
               end else begin
                  Reg_wr <= 1'b0;
                  ra_wr  <= 1'b0;
               end
            end
            default: state <= ST_INIT;
         endcase
      end
   end

endmodule
